// File: rtl/core_loader_pkg.sv
// Shared constants for the boot-time program loader:
// command codes, FSM state encodings and frame field lengths.
package core_loader_pkg;

    localparam logic [7:0] CMD_INST  = 8'h01;
    localparam logic [7:0] CMD_REG   = 8'h02;
    localparam logic [7:0] CMD_START = 8'h03;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_F_ADDR  = 4'd1;
    localparam logic [3:0] S_F_DATA  = 4'd2;
    localparam logic [3:0] S_F_IDX   = 4'd3;
    localparam logic [3:0] S_F_RDATA = 4'd4;
    localparam logic [3:0] S_F_START = 4'd5;
    localparam logic [3:0] S_WR_INST = 4'd6;
    localparam logic [3:0] S_WR_REG  = 4'd7;
    localparam logic [3:0] S_RUN     = 4'd8;
    localparam logic [3:0] S_ERR     = 4'd9;

    // Address/data fields are 4 bytes; the register index is 1 byte.
    localparam int FIELD_BYTES = 4;

    function automatic logic rx_state(input logic [3:0] s);
        return (s == S_IDLE)    || (s == S_F_ADDR)  ||
               (s == S_F_DATA)  || (s == S_F_IDX)   ||
               (s == S_F_RDATA) || (s == S_F_START);
    endfunction

endpackage

// File: rtl/core_loader_if.sv
// Byte-stream valid/ready handshake feeding the loader.
interface core_loader_if;
    logic [7:0] i_byte;
    logic       i_valid;
    logic       o_ready;

    modport master (output i_byte, output i_valid, input o_ready);
    modport slave  (input i_byte, input i_valid, output o_ready);
endinterface

// File: rtl/core_loader_le_word_collector.sv
// Little-endian 4-byte field assembler shared by all loader field states.
module le_word_collector
    import core_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt;
    logic [31:0] sr;

    // word is the value including the byte accepted this cycle
    assign word      = {byte_in, sr[31:8]};
    assign word_done = accept && (cnt == 2'(FIELD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= 2'd0;
            sr  <= 32'd0;
        end else if (accept) begin
            cnt <= cnt + 2'd1;
            sr  <= word;
        end
    end

endmodule

// File: rtl/core_loader.sv
// Frame decoder and setup-path driver that preloads the core,
// then releases it on START.
module core_loader
    import core_loader_pkg::*;
#(
    parameter int INST_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    core_loader_if.slave bus,
    output logic        o_setup,
    output logic [31:0] o_inst_mem_addr,
    output logic [31:0] o_inst_mem_data,
    output logic        o_inst_wr,
    output logic [4:0]  o_load_reg_addr,
    output logic [31:0] o_load_reg_data,
    output logic        o_reg_wr,
    output logic [31:0] o_pc_instr_start_addr,
    output logic        o_done,
    output logic        o_error
);

    localparam logic [31:0] INST_LIMIT = 32'(INST_DEPTH * 4);

    logic [3:0]  state, state_d;
    logic        ready_q;
    logic [31:0] addr_q;
    logic [4:0]  idx_q;
    logic        acc, col_acc, done;
    logic [31:0] word;
    logic        addr_bad;

    assign bus.o_ready = ready_q;
    assign acc         = bus.i_valid && ready_q;
    assign col_acc     = acc && ((state == S_F_ADDR)  ||
                                 (state == S_F_DATA)  ||
                                 (state == S_F_RDATA) ||
                                 (state == S_F_START));
    assign addr_bad    = (word[1:0] != 2'b00) || (word >= INST_LIMIT);

    le_word_collector u_col (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == S_IDLE),
        .accept    (col_acc),
        .byte_in   (bus.i_byte),
        .word      (word),
        .word_done (done)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (acc) begin
                    unique case (1'b1)
                        (bus.i_byte == CMD_INST):  state_d = S_F_ADDR;
                        (bus.i_byte == CMD_REG):   state_d = S_F_IDX;
                        (bus.i_byte == CMD_START): state_d = S_F_START;
                        default:                   state_d = S_ERR;
                    endcase
                end
            end
            S_F_ADDR:
                if (done) state_d = addr_bad ? S_ERR : S_F_DATA;
            S_F_DATA:
                if (done) state_d = S_WR_INST;
            S_F_IDX:
                if (acc) state_d = (bus.i_byte[7:5] != 3'd0) ? S_ERR : S_F_RDATA;
            S_F_RDATA:
                if (done) state_d = S_WR_REG;
            S_F_START:
                if (done) state_d = (word[1:0] != 2'b00) ? S_ERR : S_RUN;
            S_WR_INST: state_d = S_IDLE;
            S_WR_REG:  state_d = S_IDLE;
            S_RUN:     state_d = S_RUN;
            S_ERR:     state_d = S_ERR;
            default:   state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_IDLE;
            ready_q               <= 1'b1;
            addr_q                <= 32'd0;
            idx_q                 <= 5'd0;
            o_setup               <= 1'b1;
            o_inst_mem_addr       <= 32'd0;
            o_inst_mem_data       <= 32'd0;
            o_inst_wr             <= 1'b0;
            o_load_reg_addr       <= 5'd0;
            o_load_reg_data       <= 32'd0;
            o_reg_wr              <= 1'b0;
            o_pc_instr_start_addr <= 32'd0;
            o_done                <= 1'b0;
            o_error               <= 1'b0;
        end else begin
            state     <= state_d;
            ready_q   <= rx_state(state_d);
            o_inst_wr <= 1'b0;
            o_reg_wr  <= 1'b0;
            if (state == S_F_ADDR && done)
                addr_q <= word;
            if (state == S_F_IDX && acc)
                idx_q <= bus.i_byte[4:0];
            if (state == S_F_DATA && done) begin
                o_inst_mem_addr <= addr_q;
                o_inst_mem_data <= word;
                o_inst_wr       <= 1'b1;
            end
            // Register x0 is hardwired, so its write is dropped silently
            if (state == S_F_RDATA && done && idx_q != 5'd0) begin
                o_load_reg_addr <= idx_q;
                o_load_reg_data <= word;
                o_reg_wr        <= 1'b1;
            end
            if (state == S_F_START && state_d == S_RUN) begin
                o_pc_instr_start_addr <= word;
                o_done                <= 1'b1;
                o_setup               <= 1'b0;
            end
            if (state_d == S_ERR)
                o_error <= 1'b1;
        end
    end

endmodule

// File: doc/core_loader.md
# core_loader

Boot-time program loader upstream of the pipelined core. Consumes a byte stream over a valid/ready handshake, decodes load frames, and drives the core's setup-path inputs: instruction-memory write address/data, register preload address/data, and start PC. Holds the core in setup until a START frame arrives, then releases it and goes idle until reset.

## Interface
- `INST_DEPTH`, 1024: instruction memory depth in 32-bit words; byte addresses ≥ INST_DEPTH*4 are rejected.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `i_byte` in 8: stream byte.
- `i_valid` in 1: `i_byte` valid.
- `o_ready` out 1: loader accepts a byte this cycle.
- `o_setup` out 1: drives the core `setup` input; high while loading.
- `o_inst_mem_addr` out 32: instruction write byte address.
- `o_inst_mem_data` out 32: instruction write data.
- `o_inst_wr` out 1: one-cycle strobe; addr and data are valid in the same cycle.
- `o_load_reg_addr` out 5: register index.
- `o_load_reg_data` out 32: register data.
- `o_reg_wr` out 1: one-cycle strobe.
- `o_pc_instr_start_addr` out 32: start PC; held after START.
- `o_done` out 1: level signal; load complete, core running.
- `o_error` out 1: sticky error flag; cleared only by reset.

## Operation
- Frame formats. All multi-byte fields are little-endian, first byte = bits[7:0].
  - 0x01 INST: addr[4], data[4].
  - 0x02 REG: idx[1], data[4].
  - 0x03 START: addr[4].
- FSM states: IDLE, F_ADDR, F_DATA, F_IDX, F_RDATA, F_START, WR_INST, WR_REG, RUN, ERR.
- IDLE: `o_ready`=1. On an accepted byte:
  - 0x01 → F_ADDR; 0x02 → F_IDX; 0x03 → F_START.
  - Any other value → ERR.
- Field states (F_*): `o_ready`=1.
  - A 2-bit byte counter and a 32-bit shift register collect the bytes.
  - The counter advances only on an accepted byte (`i_valid`&&`o_ready`); a bubble on `i_valid` holds the counter and shift register.
- F_ADDR after 4 bytes:
  - addr[1:0]≠0 or addr ≥ INST_DEPTH*4 → ERR at the end of the frame's address field (the data bytes are not consumed).
  - Otherwise → F_DATA.
- F_DATA after 4 bytes → WR_INST.
- F_IDX:
  - idx[7:5]≠0 → ERR.
  - Otherwise latch idx[4:0] → F_RDATA.
- F_RDATA after 4 bytes → WR_REG.
- WR_INST: `o_ready`=0; `o_inst_wr`=1 for exactly one cycle → IDLE.
- WR_REG: `o_ready`=0; `o_reg_wr`=1 for one cycle, except idx=0, where the strobe is suppressed → IDLE.
- F_START after 4 bytes:
  - addr[1:0]≠0 → ERR.
  - Otherwise latch into `o_pc_instr_start_addr` → RUN.
- RUN: `o_setup`=0, `o_done`=1, `o_ready`=0. Absorbing until reset.
- ERR: `o_error`=1, `o_setup`=1, `o_ready`=0. Absorbing until reset.
- `o_inst_mem_*` and `o_load_reg_*` hold their last written values between strobes.

## Timing
- Reset values:
  - State IDLE; `o_ready`=1, `o_setup`=1.
  - All address/data outputs 0.
  - `o_inst_wr`, `o_reg_wr`, `o_done`, `o_error` = 0.
  - Byte counter 0.
- Reset mid-frame discards the partial frame; no strobe is issued.
- The strobe asserts in the cycle after the last data byte is accepted.
- Minimum frame cost: INST 9 byte-cycles + 1 strobe cycle; REG 6 + 1; START 5, with `o_done` rising the cycle after the 5th byte.
- `o_setup` falls in the same cycle `o_done` rises.
- `o_ready` is a registered function of state only; it never depends on `i_valid` combinationally.
- A strobe and a byte acceptance never coincide.

## Structure
- Shared package `core_loader_pkg` contains:
  - command codes `CMD_INST`=8'h01, `CMD_REG`=8'h02, `CMD_START`=8'h03;
  - the state enumeration;
  - the frame field lengths.
- Sub-module `le_word_collector`: 2-bit counter plus 32-bit shift register with clear, accept, and `word_done` outputs. Reused by all field states.
- Top level contains the FSM, the range/alignment checks, and the output registers.

## Test plan
- Reset, then INST frame `01 00 00 00 00 13 00 00 00` → one `o_inst_wr` pulse with addr=0x0, data=0x00000013; `o_ready` low for that one cycle.
- REG frame `02 05 EF BE AD DE` with random `i_valid` gaps → single `o_reg_wr` pulse, addr=5, data=0xDEADBEEF. REG frame with idx `00` → no strobe, returns to IDLE.
- START frame `03 40 00 00 00` → `o_pc_instr_start_addr`=0x40, `o_done`=1, `o_setup`=0, `o_ready`=0; further bytes are ignored.
- Error cases:
  - INST addr 0x00001000 with INST_DEPTH=1024 → `o_error`=1, no `o_inst_wr`.
  - Command byte 0x7F → ERR.
  - START addr 0x42 → ERR.
- Reset asserted after the 3rd byte of an INST frame → no strobe; the next full frame writes correctly.
- Back-to-back INST frames at full rate → consecutive strobes 10 cycles apart with correct data.
